// File: rtl/rr_mux_nto1.sv
// N-to-1 registered multiplexer with per-channel valid/ready handshakes.
// One channel is granted per cycle, chosen by an external select or by round-robin.
module rr_mux_nto1 #(
    parameter int N  = 8,
    parameter int W  = 8,
    localparam int SW = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N*W-1:0]   in_data,
    input  logic [N-1:0]     in_valid,
    output logic [N-1:0]     in_ready,
    input  logic             mode,
    input  logic [SW-1:0]    sel,
    output logic [W-1:0]     out_data,
    output logic [SW-1:0]    out_chan,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [W-1:0]  r_out_data;
    logic [SW-1:0] r_out_chan;
    logic          r_out_valid;
    logic [SW-1:0] r_ptr;

    logic          w_load_en;
    logic          w_gnt_any;
    logic [SW-1:0] w_gnt_idx;
    logic [N-1:0]  w_grant;
    logic [W-1:0]  w_sel_data;

    assign w_load_en = !r_out_valid || out_ready;

    // Round-robin scan starts just after the last granted channel and ends on it.
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        if (mode) begin
            for (int k = 1; k <= N; k++) begin
                if (!w_gnt_any && in_valid[(int'(r_ptr) + k) % N]) begin
                    w_gnt_any = 1'b1;
                    w_gnt_idx = SW'((int'(r_ptr) + k) % N);
                end
            end
        end else if (int'(sel) < N) begin
            if (in_valid[sel]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = sel;
            end
        end
    end

    always_comb begin
        w_grant = '0;
        if (w_gnt_any) begin
            w_grant[w_gnt_idx] = 1'b1;
        end
    end

    assign w_sel_data = in_data[int'(w_gnt_idx)*W +: W];

    // Reset gates in_ready so no producer sees an acceptance while rst is held.
    assign in_ready = (w_load_en && !rst) ? w_grant : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_data  <= '0;
            r_out_chan  <= '0;
            r_out_valid <= 1'b0;
            r_ptr       <= SW'(N - 1);
        end else if (w_load_en) begin
            if (w_gnt_any) begin
                r_out_data  <= w_sel_data;
                r_out_chan  <= w_gnt_idx;
                r_out_valid <= 1'b1;
                if (mode) begin
                    r_ptr <= w_gnt_idx;
                end
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_chan  = r_out_chan;
    assign out_valid = r_out_valid;

endmodule

// File: doc/rr_mux_nto1.md
# rr_mux_nto1

Parametrised N-to-1, W-bit registered multiplexer with per-channel valid/ready handshakes. It is the successor to the fixed 2:1, 4:1 and 8:1 combinational multiplexers. It selects one requesting channel per cycle, either by an externally supplied select (fixed mode) or by a round-robin arbiter, and presents the result through a single registered output stage. It sits between several producers and one shared consumer, for example a shared bus, a display or a UART transmitter.

## Interface
- N, 8, number of input channels (2..16)
- W, 8, data width per channel (1..32)
- SW, $clog2(N), select/channel-index width (derived, not overridden)

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_data  in  N*W  channel i occupies bits [i*W +: W]
- in_valid  in  N  channel i has a word to offer
- in_ready  out  N  channel i's word is accepted this cycle
- mode  in  1  0 = fixed select, 1 = round-robin
- sel  in  SW  channel index used in fixed mode
- out_data  out  W  registered selected word
- out_chan  out  SW  index of the channel that produced out_data
- out_valid  out  1  out_data/out_chan hold a word
- out_ready  in  1  consumer accepts the word this cycle

## Operation
- Reset values: out_data=0, out_chan=0, out_valid=0, in_ready=0, round-robin pointer ptr=N-1, so channel 0 has top priority after reset.
- load_en = !out_valid || out_ready. The output register may load when empty or when it is drained in the same cycle.
- Grant, combinational, at most one bit set:
  - fixed mode: grant[sel] = in_valid[sel]. If sel >= N, there is no grant.
  - round-robin: grant goes to the first i with in_valid[i], scanning ptr+1, ptr+2, …, wrapping modulo N, ending at ptr.
- in_ready[i] = load_en && grant[i].
- Transfer on channel i occurs when in_valid[i] && in_ready[i].
- On a transfer: out_data <= in_data[i], out_chan <= i, out_valid <= 1.
- In round-robin mode only, a transfer also sets ptr <= i.
- ptr is never changed by fixed-mode transfers.
- If load_en is 1 and there is no grant: out_valid <= 0 (out_data and out_chan hold their old values).
- If load_en is 0: all output registers hold, and in_ready is all-zero.
- Mode and sel are sampled every cycle. A change affects the next grant only; a word already in the output register is unaffected.
- Channels that are not granted are not consumed. A producer must hold in_data/in_valid stable until its transfer.
- Fairness: in round-robin mode, with all N channels continuously valid and out_ready=1, each channel is granted exactly once every N cycles.

## Timing
- Latency: 1 cycle from the accepting edge to out_valid/out_data.
- Throughput: 1 word per cycle while out_ready=1 and any grant exists.
- Back-pressure: out_ready=0 with out_valid=1 freezes the output register and ptr, and forces in_ready=0 in that same cycle.
- There is a combinational path out_ready → in_ready, which is intended. No path exists from in_data to any output.
- Wrap-around: with ptr=N-1, the scan starts at 0. With only the ptr channel valid, that channel is granted again.
- Reset asserted mid-transfer: all outputs go to their reset values immediately (asynchronously), the pending word is dropped, and in_ready=0 while rst=1. The first grant after release follows the reset priority.

## Test plan
- Reset, N=8, W=8: assert rst mid-stream with out_valid=1 → out_valid, out_data, out_chan and in_ready are all 0 immediately. After release, all in_valid=1 and out_ready=1 → first out_chan=0.
- Fixed mode, sel=5, in_data ch5=0xA5, all in_valid=1 → out_data=0xA5 and out_chan=5 one cycle later; in_ready=8'b0010_0000. With sel=9 at N=16 but in_valid[9]=0 → out_valid drops to 0 next cycle.
- Round-robin, all 8 channels valid, ch i data = 0x10+i, out_ready=1 for 16 cycles → out_chan sequence 0,1,…,7,0,…,7, one word per cycle.
- Round-robin, only ch3 and ch6 valid → out_chan alternates 3,6,3,6. Drop ch6 → 3,3,3.
- Back-pressure: out_ready=0 for 4 cycles while holding out_data=0x12 → out_data stays 0x12, in_ready=0, and ptr unchanged. On release, the next grant is the next valid channel after the held one.
- Mode switch: in round-robin, last grant ch2. Switch to fixed sel=0 for 2 words, then back to round-robin with all valid → next out_chan=3, since ptr was kept at 2.
